// File: rtl/fetch_queue_unit_if.sv
// Fetch-unit signal bundle: instruction-memory request/response, datapath output and redirect.
// master = fetch unit side, slave = memory/datapath side.
interface fetch_queue_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_data, out_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch stage: issues word-aligned fetches, buffers in-order responses tagged
// with their PC in a DEPTH-entry FIFO, and flushes everything on a branch/jump redirect.
module fetch_queue_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                clk,
    input logic                reset,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [31:0]   r_fetch_pc, w_fetch_pc_d;
    logic [31:0]   r_resp_pc, w_resp_pc_d;
    logic [CW-1:0] r_count, w_count_d;
    logic [CW-1:0] r_inflight, w_inflight_d;
    logic [CW-1:0] r_discard, w_discard_d;
    logic [PW-1:0] r_head, w_head_d;
    logic [PW-1:0] r_tail, w_tail_d;
    logic [31:0]   r_instr [DEPTH];
    logic [31:0]   r_pc    [DEPTH];

    logic          w_issue, w_pop, w_keep, w_drop;
    logic [CW:0]   w_occupancy;
    logic [31:0]   w_redirect_pc;

    // Space is judged on registered state only, so a same-cycle pop never frees a slot early.
    assign w_occupancy   = {1'b0, r_count} + {1'b0, r_inflight};
    assign w_redirect_pc = bus.redirect_pc & ~32'h3;

    assign bus.imem_req_valid = !reset && !bus.redirect_valid && (32'(w_occupancy) < DEPTH);
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.out_valid      = !reset && (r_count != '0) && !bus.redirect_valid;
    assign bus.out_instr      = reset ? 32'h0 : r_instr[r_head];
    assign bus.out_pc         = reset ? 32'h0 : r_pc[r_head];

    assign w_issue = bus.imem_req_valid && bus.imem_req_ready;
    assign w_pop   = bus.out_valid && bus.out_ready;
    assign w_drop  = bus.imem_resp_valid && (r_discard != '0);
    assign w_keep  = bus.imem_resp_valid && (r_discard == '0) && !bus.redirect_valid;

    always_comb begin
        w_fetch_pc_d = r_fetch_pc;
        w_resp_pc_d  = r_resp_pc;
        w_count_d    = r_count;
        w_inflight_d = r_inflight;
        w_discard_d  = r_discard;
        w_head_d     = r_head;
        w_tail_d     = r_tail;
        if (bus.redirect_valid) begin
            w_fetch_pc_d = w_redirect_pc;
            w_resp_pc_d  = w_redirect_pc;
            w_count_d    = '0;
            w_head_d     = '0;
            w_tail_d     = '0;
            w_inflight_d = r_inflight - CW'(bus.imem_resp_valid);
            // Everything still outstanding after this cycle belongs to the old path.
            w_discard_d  = w_inflight_d;
        end else begin
            if (w_issue) begin
                w_fetch_pc_d = r_fetch_pc + 32'd4;
            end
            w_inflight_d = r_inflight + CW'(w_issue) - CW'(bus.imem_resp_valid);
            if (w_drop) begin
                w_discard_d = r_discard - CW'(1);
            end
            if (w_keep) begin
                w_tail_d    = r_tail + PW'(1);
                w_resp_pc_d = r_resp_pc + 32'd4;
            end
            if (w_pop) begin
                w_head_d = r_head + PW'(1);
            end
            w_count_d = r_count + CW'(w_keep) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_pc <= RESET_PC;
            r_resp_pc  <= RESET_PC;
            r_count    <= '0;
            r_inflight <= '0;
            r_discard  <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_instr[i] <= 32'h0;
                r_pc[i]    <= 32'h0;
            end
        end else begin
            r_fetch_pc <= w_fetch_pc_d;
            r_resp_pc  <= w_resp_pc_d;
            r_count    <= w_count_d;
            r_inflight <= w_inflight_d;
            r_discard  <= w_discard_d;
            r_head     <= w_head_d;
            r_tail     <= w_tail_d;
            if (w_keep) begin
                r_instr[r_tail] <= bus.imem_resp_data;
                r_pc[r_tail]    <= r_resp_pc;
            end
        end
    end
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Scoreboard bench for fetch_queue_unit: a latency-configurable memory model checks request
// addresses, a separate monitor checks every consumed FIFO head against expected PCs.
module tb_fetch_queue_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_queue_unit_if fq ();
    fetch_queue_unit_if fqb ();

    fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fq.master)
    );

    // Second instance only watches the address sequence across the 32-bit wrap.
    fetch_queue_unit #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (fqb.master)
    );

    assign fqb.imem_req_ready  = 1'b1;
    assign fqb.imem_resp_valid = 1'b0;
    assign fqb.imem_resp_data  = 32'h0;
    assign fqb.out_ready       = 1'b0;
    assign fqb.redirect_valid  = 1'b0;
    assign fqb.redirect_pc     = 32'h0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int lat = 1;
    bit mem_ready = 1'b1;
    bit rdy_en = 1'b0;
    int n_acc = 0;
    int first_acc = -1;
    int first_val = -1;
    logic [31:0] exp_pc_q[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] pend_addr[$];
    int          pend_due[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic wait_drain(input string name);
        int k = 0;
        while ((exp_pc_q.size() > 0 || exp_addr_q.size() > 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        n_cmp++;
        if (exp_pc_q.size() > 0 || exp_addr_q.size() > 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d outputs and %0d requests still pending, expected 0",
                     name, exp_pc_q.size(), exp_addr_q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fq.redirect_valid = 1'b0;
        rdy_en = 1'b0;
        exp_pc_q.delete();
        exp_addr_q.delete();
        pend_addr.delete();
        pend_due.delete();
        repeat (2) @(negedge clk);
        n_acc = 0;
        first_acc = -1;
        first_val = -1;
        reset = 1'b0;
    endtask

    // Memory model: in-order responses `lat` cycles after acceptance.
    initial begin
        fq.imem_resp_valid = 1'b0;
        fq.imem_resp_data  = 32'h0;
        fq.imem_req_ready  = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_addr.delete();
                pend_due.delete();
                fq.imem_resp_valid = 1'b0;
            end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
                fq.imem_resp_valid = 1'b1;
                fq.imem_resp_data  = mem_word(pend_addr[0]);
                void'(pend_addr.pop_front());
                void'(pend_due.pop_front());
            end else begin
                fq.imem_resp_valid = 1'b0;
                fq.imem_resp_data  = 32'h0;
            end
            fq.imem_req_ready = mem_ready;
            #2;
            if (!reset && fq.imem_resp_valid)
                assert (dut.r_inflight != 0) else $error("response with nothing in flight");
            if (!reset && fq.imem_req_valid && fq.imem_req_ready) begin
                pend_addr.push_back(fq.imem_req_addr);
                pend_due.push_back(cyc + lat);
                if (n_acc == 0) first_acc = cyc;
                n_acc++;
                if (exp_addr_q.size() > 0) check("req_addr", fq.imem_req_addr, exp_addr_q.pop_front());
            end
        end
    end

    // Output monitor: consumes heads only while expectations are queued.
    initial begin
        logic [31:0] pc;
        fq.out_ready = 1'b0;
        forever begin
            @(negedge clk);
            fq.out_ready = rdy_en && (exp_pc_q.size() > 0);
            #2;
            if (!reset && fq.out_valid && first_val < 0) first_val = cyc;
            if (!reset && fq.out_valid && fq.out_ready) begin
                pc = exp_pc_q.pop_front();
                check("out_pc", fq.out_pc, pc);
                check("out_instr", fq.out_instr, mem_word(pc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got;
        logic [31:0] wrap_addr [3];
        wrap_addr = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
        fq.redirect_valid = 1'b0;
        fq.redirect_pc    = 32'h0;

        // Outputs while reset is held
        #1;
        check("rst_req_valid", 32'(fq.imem_req_valid), 32'd0);
        check("rst_out_valid", 32'(fq.out_valid), 32'd0);
        check("rst_out_instr", fq.out_instr, 32'h0);
        check("rst_out_pc", fq.out_pc, 32'h0);
        check("rst_b_req_valid", 32'(fqb.imem_req_valid), 32'd0);

        // 1: streaming with single-cycle memory
        lat = 1;
        mem_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_pc_q.push_back(32'(4 * i));
            exp_addr_q.push_back(32'(4 * i));
        end
        rdy_en = 1'b1;
        wait_drain("t1");
        check("t1_latency", 32'(first_val - first_acc), 32'd2);

        // 2: back-pressure fills exactly DEPTH entries, then drains and resumes
        do_reset();
        for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'(4 * i));
        repeat (20) @(negedge clk);
        #2;
        check("t2_accepts", 32'(n_acc), 32'd4);
        check("t2_req_valid_full", 32'(fq.imem_req_valid), 32'd0);
        for (int i = 0; i < 5; i++) exp_pc_q.push_back(32'(4 * i));
        exp_addr_q.push_back(32'h10);
        rdy_en = 1'b1;
        wait_drain("t2");

        // 3: redirect with three stale requests in flight
        lat = 3;
        do_reset();
        for (int k = 0; k < 20 && n_acc < 3; k++) @(negedge clk);
        check("t3_inflight", 32'(n_acc), 32'd3);
        fq.redirect_pc    = 32'h40;
        fq.redirect_valid = 1'b1;
        for (int i = 0; i < 4; i++) exp_pc_q.push_back(32'h40 + 32'(4 * i));
        exp_addr_q.push_back(32'h40);
        exp_addr_q.push_back(32'h44);
        rdy_en = 1'b1;
        @(negedge clk);
        fq.redirect_valid = 1'b0;
        wait_drain("t3");

        // 4: stalled memory, then unaligned redirect target
        lat = 1;
        mem_ready = 1'b0;
        do_reset();
        repeat (5) @(negedge clk);
        #2;
        check("t4_stall_valid", 32'(fq.imem_req_valid), 32'd1);
        check("t4_stall_addr", fq.imem_req_addr, 32'h0);
        check("t4_stall_accepts", 32'(n_acc), 32'd0);
        @(negedge clk);
        fq.redirect_pc    = 32'h103;
        fq.redirect_valid = 1'b1;
        #2;
        check("t4_redir_req_valid", 32'(fq.imem_req_valid), 32'd0);
        @(negedge clk);
        fq.redirect_valid = 1'b0;
        exp_addr_q.push_back(32'h100);
        exp_addr_q.push_back(32'h104);
        exp_pc_q.push_back(32'h100);
        exp_pc_q.push_back(32'h104);
        mem_ready = 1'b1;
        rdy_en = 1'b1;
        #2;
        check("t4_redir_addr", fq.imem_req_addr, 32'h100);
        wait_drain("t4");

        // 5: fetch address wraps past 2^32
        do_reset();
        got = 0;
        for (int k = 0; k < 8; k++) begin
            #2;
            if (fqb.imem_req_valid && got < 3) begin
                check("t5_addr", fqb.imem_req_addr, wrap_addr[got]);
                got++;
            end
            @(negedge clk);
        end
        check("t5_count", 32'(got), 32'd3);

        // 6: asynchronous reset with count=3, inflight=1
        do_reset();
        for (int k = 0; k < 20 && n_acc < 4; k++) @(negedge clk);
        check("t6_accepts", 32'(n_acc), 32'd4);
        #1;
        check("t6_out_valid_pre", 32'(fq.out_valid), 32'd1);
        reset = 1'b1;
        #1;
        check("t6_out_valid_rst", 32'(fq.out_valid), 32'd0);
        check("t6_req_valid_rst", 32'(fq.imem_req_valid), 32'd0);
        do_reset();
        exp_addr_q.push_back(32'h0);
        exp_pc_q.push_back(32'h0);
        exp_pc_q.push_back(32'h4);
        rdy_en = 1'b1;
        #2;
        check("t6_out_valid_post", 32'(fq.out_valid), 32'd0);
        wait_drain("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
Instruction fetch stage that sits directly upstream of the single-cycle MIPS datapath's decode/execute logic.
- Owns the fetch PC and issues word-aligned read requests to an instruction memory over a valid/ready request channel.
- Accepts in-order responses and buffers them, tagged with their PC, in a DEPTH-entry FIFO.
- Presents the FIFO head to the datapath with a valid/ready handshake.
- A branch/jump redirect flushes the FIFO and discards all in-flight responses.

Parameters:
DEPTH, 4, FIFO entries and max in-flight requests; power of 2, >=2
RESET_PC, 32'h0000_0000, fetch PC loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  32  byte address of request, bits[1:0]=0
imem_resp_valid  in  1  response data valid, in request order
imem_resp_data  in  32  instruction word
out_valid  out  1  FIFO head valid to datapath
out_ready  in  1  datapath consumes head
out_instr  out  32  head instruction
out_pc  out  32  head instruction address
redirect_valid  in  1  branch/jump taken; single-cycle pulse
redirect_pc  in  32  new fetch target; bits[1:0] ignored (treated as 0)

Behaviour:
- Reset (async): fetch_pc=RESET_PC, resp_pc=RESET_PC, count=0, inflight=0, discard=0, FIFO pointers=0.
  - During reset: imem_req_valid=0, out_valid=0, out_instr=0, out_pc=0.
  - Instruction memory is reset by the same reset, so no pre-reset response arrives afterwards.
- Counters: count (entries held) and inflight (accepted, unanswered requests) are both clog2(DEPTH)+1 bits. discard<=inflight at all times.
- Issue: imem_req_valid = !redirect_valid && (count + inflight < DEPTH), using registered values.
  - A pop in the same cycle does not free space until the next cycle.
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (wraps modulo 2^32), inflight += 1.
  - While valid && !ready, addr is held stable.
  - Valid may drop only in a redirect cycle.
- Response: on imem_resp_valid, inflight -= 1.
  - If discard != 0: data is dropped and discard -= 1.
  - Else: {resp_pc, imem_resp_data} is written at the tail, count += 1, resp_pc += 4.
  - Space is guaranteed by the issue rule, so overflow is impossible. Bench asserts the response never arrives with inflight=0.
- Output: out_valid = (count != 0) && !redirect_valid. out_instr/out_pc = head entry.
  - Pop on out_valid && out_ready: head pointer += 1, count -= 1.
  - Push and pop in the same cycle leaves count unchanged; pointers wrap modulo DEPTH.
  - Minimum latency: request accepted in cycle N, response in N+1, out_valid in N+2.
- Redirect cycle:
  - No issue and no pop; a response arriving this cycle is dropped.
  - At the edge: count=0, pointers=0, fetch_pc=resp_pc={redirect_pc[31:2],2'b00}.
  - discard = inflight after this cycle's response decrement.
  - Redirect with an empty FIFO and inflight=0 simply reloads the PCs.
- Back-to-back redirects: the later one wins. discard recomputes from inflight, never accumulating beyond it.
- imem_req_ready held low indefinitely: the unit stalls with addr stable; no state change except via redirect/pop.
- Reset mid-operation: all state returns to reset values immediately; outputs go low asynchronously.

Test Plan:
1. Reset, zero-latency-ready memory returning mem[addr>>2], out_ready=1 -> out_pc sequence 0,4,8,12 with matching instrs; first out_valid 2 cycles after first accept.
2. out_ready=0 for 20 cycles -> exactly DEPTH=4 requests issued (0..12), count=4, req_valid low. Then out_ready=1 -> drains in order and issuing resumes at 16.
3. Memory with 3-cycle response latency and 3 in flight, redirect_pc=0x40 -> the 3 stale responses are dropped, first out_pc=0x40, no stale instr ever appears at the output.
4. redirect_pc=0x103 -> imem_req_addr=0x100 and out_pc=0x100.
5. RESET_PC=32'hFFFF_FFF8 -> addresses FFFF_FFF8, FFFF_FFFC, 0000_0000 (wrap).
6. Assert reset while count=3 and inflight=1 -> out_valid and req_valid go 0 immediately; after release, fetch restarts at RESET_PC with count=0.
